// File: rtl/uart_rx_byte_receiver.sv
// 8N1 UART receiver holding one byte in a single-entry buffer with an
// Empty/Unload_data handshake and sticky overrun/framing flags.
module uart_rx_byte_receiver #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       Clock_50,
  input  logic       Resetn,
  input  logic       Enable,
  input  logic       Unload_data,
  input  logic       UART_RX_I,
  output logic [7:0] RX_data,
  output logic       Empty,
  output logic       Overrun,
  output logic       Frame_error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          baud_cnt_q, baud_cnt_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   empty_q, empty_d;
  logic                   ovr_q, ovr_d;
  logic                   ferr_q, ferr_d;
  logic                   rx_s;

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge Clock_50) begin
    if (!Resetn) begin
      state_q    <= S_IDLE;
      sync_q     <= '1;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_q     <= '0;
      empty_q    <= 1'b1;
      ovr_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], UART_RX_I};
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      empty_q    <= empty_d;
      ovr_q      <= ovr_d;
      ferr_q     <= ferr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_d     = data_q;
    empty_d    = empty_q;
    ovr_d      = ovr_q;
    ferr_d     = ferr_q;

    if (!Enable) begin
      state_d    = S_IDLE;
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
      empty_d    = 1'b1;
      ovr_d      = 1'b0;
      ferr_d     = 1'b0;
    end else begin
      if (Unload_data && !empty_q) empty_d = 1'b1;

      case (state_q)
        S_IDLE: begin
          baud_cnt_d = '0;
          bit_cnt_d  = '0;
          if (!rx_s) state_d = S_START;
        end
        S_START: begin
          if (baud_cnt_q == HALF_LAST) begin
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_s ? S_IDLE : S_DATA;
          end else begin
            baud_cnt_d = baud_cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (baud_cnt_q == BAUD_LAST) begin
            baud_cnt_d = '0;
            shift_d    = {rx_s, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = '0;
              state_d   = S_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            baud_cnt_d = baud_cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (baud_cnt_q == BAUD_LAST) begin
            baud_cnt_d = '0;
            state_d    = S_IDLE;
            // Completion looks at the registered Empty, so a same-cycle unload
            // still counts as an overrun for the incoming byte.
            if (!rx_s) begin
              ferr_d = 1'b1;
            end else if (empty_q) begin
              data_d  = shift_q;
              empty_d = 1'b0;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            baud_cnt_d = baud_cnt_q + CW'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign RX_data     = data_q;
  assign Empty       = empty_q;
  assign Overrun     = ovr_q;
  assign Frame_error = ferr_q;

endmodule
